// File: rtl/clkgen_pkg.sv
// ---------------------------------------------------------------------------
// clkgen_pkg
//   Shared types and default timing constants for the clock-generator
//   control sequencer.
//   - state_e        : sequencer FSM states (HOLD, WAIT, SETTLE, RUN)
//   - DEF_*          : default parameter values (timing at 48 MHz)
//   - max3()         : helper used to size the shared cycle counter
// ---------------------------------------------------------------------------
package clkgen_pkg;

   typedef enum logic [1:0] {
      ST_HOLD   = 2'd0,   // DCM held in reset
      ST_WAIT   = 2'd1,   // waiting for lock, with timeout
      ST_SETTLE = 2'd2,   // lock seen, waiting for it to stay stable
      ST_RUN    = 2'd3    // clocks usable
   } state_e;

   localparam int unsigned DEF_RST_CYCLES    = 8;
   localparam int unsigned DEF_LOCK_TIMEOUT  = 48000;  // 1 ms at 48 MHz
   localparam int unsigned DEF_SETTLE_CYCLES = 16;
   localparam int unsigned DEF_RETRY_W       = 8;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Generic two-flop synchronizer for a single asynchronous level signal.
//   Output follows the input with two clk_i cycles of latency.
//   Ports:
//     clk_i   in  destination clock
//     rst_ni  in  asynchronous active-low reset, both flops clear to 0
//     d_i     in  asynchronous input level
//     q_o     out synchronized level
// ---------------------------------------------------------------------------
module sync_2ff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/clkgen_sequencer.sv
// ---------------------------------------------------------------------------
// clkgen_sequencer
//   Control-side sequencer for the clock generator. Holds the DCM in reset
//   after power-up, waits for lock (timeout and retry), requires lock to be
//   stable before raising clocks_ready, and drops clocks_ready around lock
//   loss and fast-clock (100/160 MHz) switches. Runs on clk48.
//
//   Optional feature macro: CLKGEN_STATUS_EN adds the saturating
//   retry_count output and its counter. Without it the port is absent.
//
//   Ports:
//     clk48          in   48 MHz system clock
//     rst_n          in   asynchronous active-low reset
//     clocks_locked  in   lock status from clock generator (asynchronous)
//     clksel_req     in   requested fast clock, 0=100 MHz 1=160 MHz
//     clkgen_rst     out  DCM reset, active high
//     clksel         out  fast-clock mux select
//     clocks_ready   out  clocks locked and settled
//     lock_fail      out  set on lock timeout, cleared on entry to RUN
//     retry_count    out  lock timeouts since rst_n (CLKGEN_STATUS_EN only)
//     dbg_state      out  current FSM state
//
//   Handshake: none; clksel_req is a level compared against clksel while in
//   RUN, and a mismatch is acted on in the same cycle it is seen.
// ---------------------------------------------------------------------------
module clkgen_sequencer
   import clkgen_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
   parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int unsigned RETRY_W       = DEF_RETRY_W
) (
   input  logic               clk48,
   input  logic               rst_n,
   input  logic               clocks_locked,
   input  logic               clksel_req,
   output logic               clkgen_rst,
   output logic               clksel,
   output logic               clocks_ready,
   output logic               lock_fail,
`ifdef CLKGEN_STATUS_EN
   output logic [RETRY_W-1:0] retry_count,
`endif
   output state_e             dbg_state
);

   localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

   logic             locked_s;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clkgen_rst_q, clkgen_rst_d;
   logic             clksel_q, clksel_d;
   logic             ready_q, ready_d;
   logic             lock_fail_q, lock_fail_d;
   logic             retry_inc;

   sync_2ff u_lock_sync (
      .clk_i  (clk48),
      .rst_ni (rst_n),
      .d_i    (clocks_locked),
      .q_o    (locked_s)
   );

   // Single shared counter: cleared on every state entry, so its meaning
   // (reset length, lock wait, settle length) follows the current state.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      clkgen_rst_d = clkgen_rst_q;
      clksel_d     = clksel_q;
      ready_d      = ready_q;
      lock_fail_d  = lock_fail_q;
      retry_inc    = 1'b0;

      case (state_q)
         ST_HOLD: begin
            clkgen_rst_d = 1'b1;
            if (cnt_q == RST_LAST) begin
               state_d      = ST_WAIT;
               cnt_d        = '0;
               clkgen_rst_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_WAIT: begin
            // Lock is checked first so it wins over a same-cycle timeout.
            if (locked_s) begin
               state_d = ST_SETTLE;
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_d      = ST_HOLD;
               cnt_d        = '0;
               clkgen_rst_d = 1'b1;
               lock_fail_d  = 1'b1;
               retry_inc    = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_SETTLE: begin
            if (!locked_s) begin
               state_d      = ST_HOLD;
               cnt_d        = '0;
               clkgen_rst_d = 1'b1;
            end else if (cnt_q == SETTLE_LAST) begin
               state_d     = ST_RUN;
               cnt_d       = '0;
               ready_d     = 1'b1;
               lock_fail_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_RUN: begin
            // Lock loss has priority; a pending select change is picked up
            // the next time RUN is reached.
            if (!locked_s) begin
               state_d      = ST_HOLD;
               cnt_d        = '0;
               clkgen_rst_d = 1'b1;
               ready_d      = 1'b0;
            end else if (clksel_req != clksel_q) begin
               state_d  = ST_SETTLE;
               cnt_d    = '0;
               clksel_d = clksel_req;
               ready_d  = 1'b0;
            end
         end

         default: begin
            state_d      = ST_HOLD;
            cnt_d        = '0;
            clkgen_rst_d = 1'b1;
            ready_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_HOLD;
         cnt_q        <= '0;
         clkgen_rst_q <= 1'b1;
         clksel_q     <= 1'b0;
         ready_q      <= 1'b0;
         lock_fail_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         clkgen_rst_q <= clkgen_rst_d;
         clksel_q     <= clksel_d;
         ready_q      <= ready_d;
         lock_fail_q  <= lock_fail_d;
      end
   end

`ifdef CLKGEN_STATUS_EN
   logic [RETRY_W-1:0] retry_q, retry_d;

   // Saturating: holds at all-ones rather than wrapping.
   always_comb begin
      retry_d = retry_q;
      if (retry_inc && (retry_q != '1)) begin
         retry_d = retry_q + RETRY_W'(1);
      end
   end

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         retry_q <= '0;
      end else begin
         retry_q <= retry_d;
      end
   end

   assign retry_count = retry_q;
`else
   logic unused_retry_inc;
   assign unused_retry_inc = retry_inc;
`endif

   assign clkgen_rst   = clkgen_rst_q;
   assign clksel       = clksel_q;
   assign clocks_ready = ready_q;
   assign lock_fail    = lock_fail_q;
   assign dbg_state    = state_q;

endmodule
